pkt_rx_buffer: RTL and testbench
================================

# pkt_rx_buffer

Credit-based flit buffer that sits between the router local output port and the ddma receive side. It stores incoming flits in a circular FIFO and parses each packet (header flit, size flit, then `size` payload flits) on both the write and read sides. It can hold a packet back until it is fully buffered (store-and-forward), so the ddma sees gap-free payload bursts.

## Interface
- `FLIT_WIDTH`, 32: flit and data width.
- `DEPTH`, 16: FIFO entries; power of two, ≥4.
- `STORE_AND_FORWARD`, 1: 1 = release a packet only when complete (or when the FIFO is full); 0 = cut-through.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_tx`  in  1  upstream (router) presents a flit.
- `in_data`  in  FLIT_WIDTH  upstream flit.
- `in_credit`  out  1  buffer can accept; a flit is written on any edge with `in_tx && in_credit`.
- `out_tx`  out  1  flit available to the ddma.
- `out_data`  out  FLIT_WIDTH  flit at the read pointer.
- `out_credit`  in  1  ddma accepts; a flit is popped on any edge with `out_tx && out_credit`.
- `pkt_count`  out  $clog2(DEPTH+1)  number of complete packets fully held in the FIFO.
- `level`  out  $clog2(DEPTH+1)  FIFO occupancy.
- `busy`  out  1  input or output parser is mid-packet.

## Operation
- **FIFO**
  - Register array with `wr_ptr`/`rd_ptr` of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a `level` counter.
  - `in_credit = (level != DEPTH)`.
  - `out_data = mem[rd_ptr]`, a combinational read.
- **Input parser** (per accepted flit)
  - States: IN_HEADER, IN_SIZE, IN_PAYLOAD.
  - IN_HEADER → IN_SIZE.
  - IN_SIZE: latch `in_rem = in_data`. If the value is 0, the packet is complete; go to IN_HEADER. Otherwise go to IN_PAYLOAD.
  - IN_PAYLOAD: `in_rem` decrements. On the flit with `in_rem == 1`, the packet is complete; go to IN_HEADER.
  - "Complete" raises a one-cycle `pkt_in_done`.
- **Output parser** (per popped flit)
  - States: OUT_HEADER, OUT_SIZE, OUT_PAYLOAD.
  - Uses the same transitions as the input parser, driven by `out_rem`. The last popped flit of a packet raises `pkt_out_done`.
- **pkt_count**
  - +1 on `pkt_in_done`, −1 on `pkt_out_done`.
  - Both in the same cycle: unchanged.
  - The count never underflows: in cut-through mode, decrement only when `pkt_count > 0`.
- **Release gate**
  - STORE_AND_FORWARD=1: `release = (out_state != OUT_HEADER) || pkt_count > 0 || level == DEPTH`. The full-FIFO term prevents deadlock on packets longer than DEPTH−2; such a packet then streams cut-through.
  - STORE_AND_FORWARD=0: `release = 1`.
  - `out_tx = (level != 0) && release`.
- **busy** = `(in_state != IN_HEADER) || (out_state != OUT_HEADER)`.
- **Arithmetic**
  - The size field is a full FLIT_WIDTH unsigned value; `in_rem`/`out_rem` are FLIT_WIDTH wide.
  - `level` update: +1 on push only, −1 on pop only, unchanged when both occur.

## Timing
- **Reset values**
  - Pointers, `level`, and `pkt_count` = 0.
  - Both parsers in the *_HEADER state; `in_rem`/`out_rem` = 0.
  - Outputs: `in_credit`=1, `out_tx`=0, `pkt_count`=0, `level`=0, `busy`=0. `out_data` is don't-care (the array is not cleared).
  - A reset mid-packet discards all buffered flits and partial parse state.
- **Latency**
  - A flit written at edge N is visible on `out_tx`/`out_data` after edge N (cut-through: next cycle).
  - In store-and-forward mode, the header is visible the cycle after the last payload flit is written.
- **Throughput and handshake**
  - Throughput is one flit per cycle per side, with simultaneous push and pop allowed.
  - Full with a simultaneous pop: the push is refused that cycle (`in_credit`=0); credit returns on the next cycle.
  - Empty with `in_tx`: written, but not poppable in the same cycle (no bypass).
  - `out_tx` may drop mid-packet only in cut-through mode (FIFO empty). In store-and-forward mode a complete packet is delivered without gaps while `out_credit` stays high.
  - `out_data` is stable while `out_tx && !out_credit`.

## Test plan
- **Reset / idle:** assert `reset` for 2 cycles with `in_tx`=1 → no writes; after release: `in_credit`=1, `out_tx`=0, `level`=0, `pkt_count`=0.
- **Store-and-forward, single packet:** SAF=1; send header 0x11, size 3, payload A/B/C back-to-back → `out_tx` stays 0 until the cycle after C is written, and `pkt_count` is 1 that cycle. With `out_credit`=1, five consecutive pops 0x11, 3, A, B, C; `pkt_count` returns to 0.
- **Zero-size packet:** size 0 → `pkt_count` increments on the size flit; exactly 2 flits are output and the parsers return to *_HEADER.
- **Overflow fallback:** DEPTH=16, SAF=1, size 20 with `out_credit`=0 → `in_credit` drops at level 16 and `out_tx` rises. Enable `out_credit` → all 22 flits are delivered in order; `pkt_count` ends at 0.
- **Cut-through with backpressure:** SAF=0; random `in_tx`/`out_credit` across 3 back-to-back packets (sizes 1, 0, 7) → output sequence equals input sequence. Pushes with `in_credit`=0 are never accepted, and `level` matches the scoreboard every cycle.
- **Mid-packet reset:** reset after the size flit of a size-5 packet → after reset, a new packet (size 2) is parsed correctly and `pkt_count` reaches 1.

Source files
------------

// File: rtl/pkt_rx_buffer.sv
// Purpose: credit-based circular flit FIFO between router local port and ddma rx, parsing packets on both sides.
// Latency: a written flit is visible the next cycle (cut-through) or once its packet is complete (store-and-forward).
// Backpressure: in_credit drops only when full; out_tx is gated by the release rule and held stable while out_credit is low.
module pkt_rx_buffer #(
  parameter int FLIT_WIDTH        = 32,
  parameter int DEPTH             = 16,
  parameter int STORE_AND_FORWARD = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           in_tx,
  input  logic [FLIT_WIDTH-1:0]          in_data,
  output logic                           in_credit,
  output logic                           out_tx,
  output logic [FLIT_WIDTH-1:0]          out_data,
  input  logic                           out_credit,
  output logic [$clog2(DEPTH+1)-1:0]     pkt_count,
  output logic [$clog2(DEPTH+1)-1:0]     level,
  output logic                           busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
  localparam logic [FLIT_WIDTH-1:0] REM_ONE = FLIT_WIDTH'(1);

  typedef enum logic [1:0] {IN_HEADER, IN_SIZE, IN_PAYLOAD} in_state_t;
  typedef enum logic [1:0] {OUT_HEADER, OUT_SIZE, OUT_PAYLOAD} out_state_t;

  logic [FLIT_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  in_state_t             in_state, in_state_nxt;
  out_state_t            out_state, out_state_nxt;
  logic [FLIT_WIDTH-1:0] in_rem, in_rem_nxt, out_rem, out_rem_nxt;
  logic                  pkt_in_done, pkt_out_done;
  logic                  push, pop, release_ok;

  assign push      = in_tx && in_credit;
  assign pop       = out_tx && out_credit;
  assign in_credit = (level != FULL_LEVEL);
  assign out_data  = mem[rd_ptr];

  // Flit storage is deliberately not reset; contents are only meaningful below level.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Pointers, occupancy and complete-packet count.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      pkt_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + CW'(1);
        2'b01:   level <= level - CW'(1);
        default: level <= level;
      endcase
      // The decrement is guarded so the count can never wrap below zero.
      case ({pkt_in_done, pkt_out_done && (pkt_count != '0)})
        2'b10:   pkt_count <= pkt_count + CW'(1);
        2'b01:   pkt_count <= pkt_count - CW'(1);
        default: pkt_count <= pkt_count;
      endcase
    end
  end

  // Parser state registers for both sides.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_state  <= IN_HEADER;
      out_state <= OUT_HEADER;
      in_rem    <= '0;
      out_rem   <= '0;
    end else begin
      in_state  <= in_state_nxt;
      out_state <= out_state_nxt;
      in_rem    <= in_rem_nxt;
      out_rem   <= out_rem_nxt;
    end
  end

  // Input parser next state: advances once per accepted flit.
  always_comb begin
    in_state_nxt = in_state;
    in_rem_nxt   = in_rem;
    if (push) begin
      case (in_state)
        IN_HEADER: in_state_nxt = IN_SIZE;
        IN_SIZE: begin
          in_rem_nxt   = in_data;
          in_state_nxt = (in_data == '0) ? IN_HEADER : IN_PAYLOAD;
        end
        IN_PAYLOAD: begin
          in_rem_nxt = in_rem - REM_ONE;
          if (in_rem == REM_ONE) in_state_nxt = IN_HEADER;
        end
        default: in_state_nxt = IN_HEADER;
      endcase
    end
  end

  // Output parser next state: advances once per popped flit.
  always_comb begin
    out_state_nxt = out_state;
    out_rem_nxt   = out_rem;
    if (pop) begin
      case (out_state)
        OUT_HEADER: out_state_nxt = OUT_SIZE;
        OUT_SIZE: begin
          out_rem_nxt   = out_data;
          out_state_nxt = (out_data == '0) ? OUT_HEADER : OUT_PAYLOAD;
        end
        OUT_PAYLOAD: begin
          out_rem_nxt = out_rem - REM_ONE;
          if (out_rem == REM_ONE) out_state_nxt = OUT_HEADER;
        end
        default: out_state_nxt = OUT_HEADER;
      endcase
    end
  end

  // Parser outputs: packet-complete strobes, release gate and busy flag.
  always_comb begin
    pkt_in_done  = push && (((in_state == IN_SIZE) && (in_data == '0)) ||
                            ((in_state == IN_PAYLOAD) && (in_rem == REM_ONE)));
    pkt_out_done = pop && (((out_state == OUT_SIZE) && (out_data == '0)) ||
                           ((out_state == OUT_PAYLOAD) && (out_rem == REM_ONE)));
    // A full FIFO forces release so a packet longer than the buffer cannot deadlock.
    if (STORE_AND_FORWARD != 0)
      release_ok = (out_state != OUT_HEADER) || (pkt_count != '0) || (level == FULL_LEVEL);
    else
      release_ok = 1'b1;
    out_tx = (level != '0) && release_ok;
    busy   = (in_state != IN_HEADER) || (out_state != OUT_HEADER);
  end

endmodule

// File: tb/tb_pkt_rx_buffer.sv
// Purpose: self-checking bench for pkt_rx_buffer, store-and-forward (index 0) and cut-through (index 1) instances.
// Latency: expectations come from a packet-level model (flit stream, push/pop counts, packet boundaries).
// Backpressure: in_tx and out_credit are driven randomly or per scenario; handshakes are predicted by the model.
module tb_pkt_rx_buffer;
  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_tx_i      [2];
  logic [31:0] in_data_i    [2];
  logic        out_credit_i [2];
  logic        in_credit_o  [2];
  logic        out_tx_o     [2];
  logic [31:0] out_data_o   [2];
  logic [4:0]  pkt_count_o  [2];
  logic [4:0]  level_o      [2];
  logic        busy_o       [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: planned flit stream, packet boundaries, and how far each side has advanced.
  logic [31:0] stream [$];
  int          starts [$];
  int          ends   [$];
  int          pushed, popped;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  pkt_rx_buffer #(.FLIT_WIDTH(32), .DEPTH(DEPTH), .STORE_AND_FORWARD(1)) dut_saf (
    .clock(clock), .reset(reset), .in_tx(in_tx_i[0]), .in_data(in_data_i[0]),
    .in_credit(in_credit_o[0]), .out_tx(out_tx_o[0]), .out_data(out_data_o[0]),
    .out_credit(out_credit_i[0]), .pkt_count(pkt_count_o[0]), .level(level_o[0]), .busy(busy_o[0]));

  pkt_rx_buffer #(.FLIT_WIDTH(32), .DEPTH(DEPTH), .STORE_AND_FORWARD(0)) dut_ct (
    .clock(clock), .reset(reset), .in_tx(in_tx_i[1]), .in_data(in_data_i[1]),
    .in_credit(in_credit_o[1]), .out_tx(out_tx_o[1]), .out_data(out_data_o[1]),
    .out_credit(out_credit_i[1]), .pkt_count(pkt_count_o[1]), .level(level_o[1]), .busy(busy_o[1]));

  function automatic void model_clear();
    stream.delete(); starts.delete(); ends.delete();
    pushed = 0; popped = 0;
  endfunction

  function automatic void add_pkt(input logic [31:0] hdr, input int size, input logic [31:0] base);
    starts.push_back(stream.size());
    stream.push_back(hdr);
    stream.push_back(size);
    for (int i = 0; i < size; i++) stream.push_back(base + i);
    ends.push_back(stream.size());
  endfunction

  function automatic int done_cnt(input int n);
    int c = 0;
    foreach (ends[i]) if (ends[i] <= n) c++;
    return c;
  endfunction

  function automatic bit is_mid(input int n);
    foreach (starts[i]) if (starts[i] < n && n < ends[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Called at a falling edge: drives one cycle, checks all outputs against the model, advances to the next falling edge.
  task automatic step(input int d, input logic tx, input logic ocr, output logic o_tx, output logic [31:0] o_dat);
    int lvl, pc;
    logic tx_eff, ecr, etx, ebusy;
    tx_eff = tx && (pushed < stream.size());
    in_tx_i[d]      = tx_eff;
    in_data_i[d]    = tx_eff ? stream[pushed] : $urandom;
    out_credit_i[d] = ocr;
    #1;
    lvl   = pushed - popped;
    pc    = done_cnt(pushed) - done_cnt(popped);
    ecr   = (lvl != DEPTH);
    etx   = (lvl != 0) && ((d == 1) || is_mid(popped) || (pc > 0) || (lvl == DEPTH));
    ebusy = is_mid(pushed) || is_mid(popped);
    n_checks++; if (level_o[d] !== 5'(lvl)) begin n_fail++; $display("FAIL level d=%0d cyc=%0d: got %0d expected %0d", d, cyc, level_o[d], lvl); end
    n_checks++; if (pkt_count_o[d] !== 5'(pc)) begin n_fail++; $display("FAIL pkt_count d=%0d cyc=%0d: got %0d expected %0d", d, cyc, pkt_count_o[d], pc); end
    n_checks++; if (in_credit_o[d] !== ecr) begin n_fail++; $display("FAIL in_credit d=%0d cyc=%0d: got %b expected %b", d, cyc, in_credit_o[d], ecr); end
    n_checks++; if (out_tx_o[d] !== etx) begin n_fail++; $display("FAIL out_tx d=%0d cyc=%0d: got %b expected %b", d, cyc, out_tx_o[d], etx); end
    n_checks++; if (busy_o[d] !== ebusy) begin n_fail++; $display("FAIL busy d=%0d cyc=%0d: got %b expected %b", d, cyc, busy_o[d], ebusy); end
    if (etx) begin
      n_checks++; if (out_data_o[d] !== stream[popped]) begin n_fail++; $display("FAIL out_data d=%0d cyc=%0d idx=%0d: got %h expected %h", d, cyc, popped, out_data_o[d], stream[popped]); end
    end
    o_tx  = out_tx_o[d];
    o_dat = out_data_o[d];
    @(posedge clock);
    if (tx_eff && ecr) pushed++;
    if (etx && ocr) popped++;
    @(negedge clock);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin in_tx_i[d] = 1'b0; out_credit_i[d] = 1'b0; in_data_i[d] = '0; end
    repeat (cycles) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin in_tx_i[d] = 1'b1; in_data_i[d] = $urandom; out_credit_i[d] = 1'b1; end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin in_tx_i[d] = 1'b0; out_credit_i[d] = 1'b0; end
    model_clear();
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (in_credit_o[d] !== 1'b1) begin n_fail++; $display("FAIL reset_in_credit d=%0d: got %b expected 1", d, in_credit_o[d]); end
      n_checks++; if (out_tx_o[d] !== 1'b0) begin n_fail++; $display("FAIL reset_out_tx d=%0d: got %b expected 0", d, out_tx_o[d]); end
      n_checks++; if (level_o[d] !== 5'd0) begin n_fail++; $display("FAIL reset_level d=%0d: got %0d expected 0", d, level_o[d]); end
      n_checks++; if (pkt_count_o[d] !== 5'd0) begin n_fail++; $display("FAIL reset_pkt_count d=%0d: got %0d expected 0", d, pkt_count_o[d]); end
      n_checks++; if (busy_o[d] !== 1'b0) begin n_fail++; $display("FAIL reset_busy d=%0d: got %b expected 0", d, busy_o[d]); end
    end
    @(negedge clock);
  endtask

  task automatic test_saf_single();
    logic o_tx; logic [31:0] o_dat;
    logic [31:0] exp_flits [5];
    exp_flits = '{32'h11, 32'd3, 32'hA, 32'hB, 32'hC};
    do_reset(1);
    add_pkt(32'h11, 3, 32'hA);
    for (int i = 0; i < 5; i++) begin
      step(0, 1'b1, 1'b1, o_tx, o_dat);
      n_checks++; if (o_tx !== 1'b0) begin n_fail++; $display("FAIL saf_hold flit=%0d: got out_tx %b expected 0", i, o_tx); end
    end
    #1;
    n_checks++; if (pkt_count_o[0] !== 5'd1) begin n_fail++; $display("FAIL saf_pkt_count_full: got %0d expected 1", pkt_count_o[0]); end
    for (int i = 0; i < 5; i++) begin
      step(0, 1'b0, 1'b1, o_tx, o_dat);
      n_checks++; if (o_tx !== 1'b1 || o_dat !== exp_flits[i]) begin n_fail++; $display("FAIL saf_burst i=%0d: got tx=%b data=%h expected tx=1 data=%h", i, o_tx, o_dat, exp_flits[i]); end
    end
    #1;
    n_checks++; if (pkt_count_o[0] !== 5'd0) begin n_fail++; $display("FAIL saf_pkt_count_end: got %0d expected 0", pkt_count_o[0]); end
  endtask

  task automatic test_zero_size();
    logic o_tx; logic [31:0] o_dat;
    int outs = 0;
    do_reset(1);
    add_pkt(32'h22, 0, 32'h0);
    step(0, 1'b1, 1'b0, o_tx, o_dat);
    step(0, 1'b1, 1'b0, o_tx, o_dat);
    #1;
    n_checks++; if (pkt_count_o[0] !== 5'd1) begin n_fail++; $display("FAIL zero_pkt_count: got %0d expected 1", pkt_count_o[0]); end
    for (int i = 0; i < 6; i++) begin
      step(0, 1'b0, 1'b1, o_tx, o_dat);
      if (o_tx) outs++;
    end
    #1;
    n_checks++; if (outs !== 2) begin n_fail++; $display("FAIL zero_out_count: got %0d expected 2", outs); end
    n_checks++; if (busy_o[0] !== 1'b0 || pkt_count_o[0] !== 5'd0) begin n_fail++; $display("FAIL zero_idle: got busy=%b pkt_count=%0d expected 0/0", busy_o[0], pkt_count_o[0]); end
  endtask

  task automatic test_overflow();
    logic o_tx; logic [31:0] o_dat;
    do_reset(1);
    add_pkt(32'h33, 20, $urandom);
    for (int i = 0; i < 30 && pushed < DEPTH; i++) step(0, 1'b1, 1'b0, o_tx, o_dat);
    #1;
    n_checks++; if (level_o[0] !== 5'd16 || in_credit_o[0] !== 1'b0 || out_tx_o[0] !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got level=%0d credit=%b tx=%b expected 16/0/1", level_o[0], in_credit_o[0], out_tx_o[0]); end
    for (int i = 0; i < 100 && popped < stream.size(); i++) step(0, 1'b1, 1'b1, o_tx, o_dat);
    #1;
    n_checks++; if (popped !== 22) begin n_fail++; $display("FAIL ovf_drain: got %0d flits expected 22", popped); end
    n_checks++; if (pkt_count_o[0] !== 5'd0) begin n_fail++; $display("FAIL ovf_pkt_count: got %0d expected 0", pkt_count_o[0]); end
  endtask

  task automatic test_cut_through();
    logic o_tx; logic [31:0] o_dat;
    do_reset(1);
    add_pkt(32'h44, 1, $urandom);
    add_pkt(32'h45, 0, 32'h0);
    add_pkt(32'h46, 7, $urandom);
    for (int i = 0; i < 400 && popped < stream.size(); i++)
      step(1, ($urandom % 100) < 60, ($urandom % 100) < 50, o_tx, o_dat);
    n_checks++; if (popped !== 14) begin n_fail++; $display("FAIL ct_drain: got %0d flits expected 14", popped); end
  endtask

  task automatic test_back_to_back();
    logic o_tx; logic [31:0] o_dat;
    int total;
    do_reset(1);
    for (int p = 0; p < 6; p++) add_pkt($urandom, $urandom_range(0, 11), $urandom);
    total = stream.size();
    for (int i = 0; i < 1500 && popped < total; i++)
      step(0, ($urandom % 100) < 75, ($urandom % 100) < 35, o_tx, o_dat);
    #1;
    n_checks++; if (popped !== total) begin n_fail++; $display("FAIL b2b_drain: got %0d flits expected %0d", popped, total); end
    n_checks++; if (busy_o[0] !== 1'b0 || pkt_count_o[0] !== 5'd0) begin n_fail++; $display("FAIL b2b_idle: got busy=%b pkt_count=%0d expected 0/0", busy_o[0], pkt_count_o[0]); end
  endtask

  task automatic test_mid_reset();
    logic o_tx; logic [31:0] o_dat;
    do_reset(1);
    add_pkt(32'h55, 5, $urandom);
    step(0, 1'b1, 1'b0, o_tx, o_dat);
    step(0, 1'b1, 1'b0, o_tx, o_dat);
    do_reset(1);
    add_pkt(32'h66, 2, 32'h70);
    for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b0, o_tx, o_dat);
    #1;
    n_checks++; if (pkt_count_o[0] !== 5'd1) begin n_fail++; $display("FAIL midrst_pkt_count: got %0d expected 1", pkt_count_o[0]); end
    for (int i = 0; i < 10 && popped < stream.size(); i++) step(0, 1'b0, 1'b1, o_tx, o_dat);
    n_checks++; if (popped !== 4) begin n_fail++; $display("FAIL midrst_drain: got %0d flits expected 4", popped); end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin in_tx_i[d] = 1'b0; in_data_i[d] = '0; out_credit_i[d] = 1'b0; end
    model_clear();
    @(negedge clock);
    test_reset();
    test_saf_single();
    test_zero_size();
    test_overflow();
    test_cut_through();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
